// File: rtl/dp_sequencer.sv
// Multi-cycle control sequencer for the register-file/ALU/RAM datapath:
// fetches instruction words over valid/ready and steps EXEC/MEM/WB cycles.
module dp_sequencer #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned RETIRE_W = 16,
  parameter int unsigned WRITE_R0 = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic [31:0]         instr,
  output logic                instr_ready,
  input  logic [DATA_W-1:0]   aluOut,
  input  logic [DATA_W-1:0]   ramOut,
  input  logic [3:0]          status,
  output logic                write,
  output logic [4:0]          writeReg,
  output logic [DATA_W-1:0]   data,
  output logic [4:0]          readA,
  output logic [4:0]          readB,
  output logic [4:0]          sel,
  output logic                cin,
  output logic                muxSel,
  output logic                writeRam,
  output logic                busy,
  output logic                halted,
  output logic [3:0]          flags,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED
  } state_e;

  typedef enum logic [1:0] {
    C_ALU   = 2'b00,
    C_STORE = 2'b01,
    C_LOAD  = 2'b10,
    C_HALT  = 2'b11
  } class_e;

  state_e              state_q, state_d;
  logic [23:0]         ir_q, ir_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [3:0]          flags_q, flags_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  class_e              ir_class;
  logic                unused_instr_hi;

  always_comb begin
    writeReg        = ir_q[4:0];
    readA           = ir_q[9:5];
    readB           = ir_q[14:10];
    sel             = ir_q[19:15];
    cin             = ir_q[20];
    muxSel          = ir_q[21];
    ir_class        = class_e'(ir_q[23:22]);
    busy            = (state_q != S_IDLE);
    halted          = (state_q == S_HALTED);
    flags           = flags_q;
    retired         = retired_q;
    unused_instr_hi = ^instr[31:24];
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    result_d    = result_q;
    data_d      = data_q;
    flags_d     = flags_q;
    retired_d   = retired_q;
    instr_ready = 1'b0;
    write       = 1'b0;
    writeRam    = 1'b0;
    data        = data_q;

    unique case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_d    = instr[23:0];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (ir_class)
          C_ALU: begin
            result_d = aluOut;
            flags_d  = status;
            state_d  = S_WB;
          end
          C_STORE: begin
            writeRam  = 1'b1;
            retired_d = retired_q + RETIRE_W'(1);
            state_d   = S_IDLE;
          end
          C_LOAD: state_d = S_MEM;
          C_HALT: begin
            retired_d = retired_q + RETIRE_W'(1);
            state_d   = S_HALTED;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_MEM: begin
        result_d = ramOut;
        state_d  = S_WB;
      end
      S_WB: begin
        data      = result_q;
        data_d    = result_q;
        write     = (WRITE_R0 != 0) || (ir_q[4:0] != 5'd0);
        retired_d = retired_q + RETIRE_W'(1);
        state_d   = S_IDLE;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase

    // Strobes are masked in the reset cycle so an abandoned instruction
    // never reaches the register file or RAM.
    if (reset) begin
      instr_ready = 1'b0;
      write       = 1'b0;
      writeRam    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      result_q  <= '0;
      data_q    <= '0;
      flags_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      result_q  <= result_d;
      data_q    <= data_d;
      flags_q   <= flags_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
- Multi-cycle control FSM that sits directly upstream of the register-file/ALU/RAM datapath and drives all of its control inputs.
- Accepts 32-bit instruction words over a valid/ready handshake and decodes each one.
- Sequences execute, memory and writeback cycles, and drives the writeback data bus from the latched ALU or RAM result.
- Latches ALU status flags and counts retired instructions.

Parameters:
DATA_W, 64, datapath word width (aluOut, ramOut, data)
RETIRE_W, 16, width of retired-instruction counter
WRITE_R0, 1, 0 = writebacks with dest==0 are suppressed (write stays 0)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
instr_valid  in  1  instruction word offered
instr  in  32  instruction: [4:0] dest, [9:5] srcA, [14:10] srcB, [19:15] alu sel, [20] cin, [21] useImm, [23:22] class (00 ALU, 01 STORE, 10 LOAD, 11 HALT), [31:24] ignored
instr_ready  out  1  sequencer can accept an instruction
aluOut  in  DATA_W  datapath ALU result
ramOut  in  DATA_W  datapath RAM read data
status  in  4  datapath ALU status
write  out  1  register-file write enable
writeReg  out  5  = IR[4:0]; write address and immediate operand source
data  out  DATA_W  writeback data
readA  out  5  = IR[9:5]
readB  out  5  = IR[14:10]
sel  out  5  = IR[19:15]
cin  out  1  = IR[20]
muxSel  out  1  = IR[21]; 1 = ALU A operand is writeReg zero-extended
writeRam  out  1  RAM write enable; RAM address = aluOut[7:0], RAM data = regfile A
busy  out  1  state != IDLE
halted  out  1  state == HALTED
flags  out  4  status latched from the last ALU-class instruction
retired  out  RETIRE_W  retired-instruction count; wraps modulo 2^RETIRE_W

Behaviour:
- States: IDLE, EXEC, MEM, WB, HALTED. Encoding is free.
- Reset values:
  - State IDLE; IR = 0; all decoded outputs 0.
  - write = 0, writeRam = 0, data = 0, flags = 0, retired = 0.
  - instr_ready = 1 from the first cycle after reset.
- Reset mid-operation: the in-flight instruction is abandoned. No write, no writeRam, and retired is not incremented in the reset cycle.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready, capture instr into IR and go to EXEC.
  - Otherwise stay in IDLE. instr is ignored while instr_ready = 0.
- Decoded outputs (readA, readB, sel, cin, muxSel, writeReg) are driven from IR in every state; they hold the last value in IDLE.
- EXEC (one cycle):
  - ALU: latch aluOut into the result register and status into flags; go to WB.
  - STORE: writeRam = 1 for exactly this cycle; retired += 1; go to IDLE.
  - LOAD: go to MEM. The RAM samples address aluOut[7:0] at the end of EXEC.
  - HALT: retired += 1; go to HALTED.
- MEM (one cycle, LOAD only): latch ramOut into the result register; go to WB.
- WB (one cycle):
  - data = result register.
  - write = 1 unless WRITE_R0 = 0 and IR[4:0] = 0.
  - retired += 1; go to IDLE.
- data holds the last written value outside WB.
- HALTED: instr_ready = 0, halted = 1; exits only on reset.
- Latency from handshake cycle to IDLE-again: ALU 3, STORE 2, LOAD 4, HALT never.
- Back-to-back throughput: one ALU instruction per 3 cycles. A write in WB is visible to the next instruction's EXEC reads.
- write and writeRam are never high in the same cycle and never high outside WB / EXEC respectively.
- flags change only on ALU-class EXEC; LOAD and STORE leave flags unchanged.
- retired wraps from all-ones to 0 with no error indication.

Test Plan:
- Reset: hold reset 2 cycles, then release -> instr_ready=1, busy=0, write=0, writeRam=0, flags=0, retired=0.
- ALU: issue ALU, dest=3, srcA=1, srcB=2; return aluOut=0x5, status=4'b0010 -> write=1 for exactly 1 cycle, 2 cycles after the handshake, with writeReg=3, data=0x5; flags=4'b0010; retired=1.
- STORE then LOAD: STORE (aluOut[7:0]=0x10) -> writeRam=1 for one cycle, write=0. Then LOAD dest=7 with ramOut=0xDEAD in MEM -> WB writes data=0xDEAD to reg 7 at cycle 3 after the handshake; flags unchanged.
- Immediate and R0: ALU with useImm=1, dest=0, WRITE_R0=0 -> muxSel=1, writeReg=0, write stays 0 in WB; retired still increments.
- HALT and mid-op reset: HALT -> halted=1, instr_ready=0, and further instr_valid is ignored for 10 cycles. Reset asserted during the MEM cycle of a LOAD -> no write, retired unchanged, state IDLE.
- Stream and wrap: RETIRE_W=4, 17 back-to-back ALU ops with instr_valid held high -> accepts spaced exactly 3 cycles apart; retired=1 at the end.
